// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 raster constants and types.
// Imported by the timing generator, colour stage and sprite address logic.
package vga_pkg;

    localparam int unsigned H_ACT  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_ACT  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam int unsigned HS_BEG = H_ACT + H_FP;
    localparam int unsigned HS_END = HS_BEG + H_SYNC - 1;
    localparam int unsigned VS_BEG = V_ACT + V_FP;
    localparam int unsigned VS_END = VS_BEG + V_SYNC - 1;

    localparam int unsigned PIC_X = 256;
    localparam int unsigned PIC_Y = 176;
    localparam int unsigned PIC_W = 128;
    localparam int unsigned PIC_H = 128;

    typedef logic [9:0] coord_t;

    // One registered raster sample, as seen by the colour stage.
    typedef struct packed {
        logic   hs_n;
        logic   vs_n;
        logic   act;
        logic   pic;
        logic   disp;
        logic   fs;
        coord_t h;
        coord_t v;
    } raster_t;

    localparam raster_t RASTER_IDLE = '{
        hs_n: 1'b1,
        vs_n: 1'b1,
        act:  1'b0,
        pic:  1'b0,
        disp: 1'b0,
        fs:   1'b0,
        h:    10'd0,
        v:    10'd0
    };

    // Inclusive range test on a raster coordinate.
    function automatic logic in_rng(coord_t x, coord_t lo, coord_t hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter with carry-out.
// Carry is asserted on the enabled cycle that wraps TOT-1 -> 0.
module vga_axis_counter #(
    parameter int unsigned TOT = 800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [9:0] cnt_o,
    output logic       wrap_o
);
    import vga_pkg::*;

    localparam coord_t LAST = coord_t'(TOT - 1);

    coord_t cnt_q;
    coord_t cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Next count: hold, advance, or wrap back to the first visible position.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + coord_t'(1);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, decode, one output register stage.
// All outputs are mutually aligned one clock after the counter state.
module vga_timing_gen #(
    parameter int unsigned H_ACT  = vga_pkg::H_ACT,
    parameter int unsigned H_FP   = vga_pkg::H_FP,
    parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
    parameter int unsigned H_BP   = vga_pkg::H_BP,
    parameter int unsigned V_ACT  = vga_pkg::V_ACT,
    parameter int unsigned V_FP   = vga_pkg::V_FP,
    parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
    parameter int unsigned V_BP   = vga_pkg::V_BP,
    parameter int unsigned PIC_X  = vga_pkg::PIC_X,
    parameter int unsigned PIC_Y  = vga_pkg::PIC_Y,
    parameter int unsigned PIC_W  = vga_pkg::PIC_W,
    parameter int unsigned PIC_H  = vga_pkg::PIC_H
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic       display_en,
    output logic       hsync,
    output logic       vsync,
    output logic       data_read_active,
    output logic [9:0] h_addr,
    output logic [9:0] v_addr,
    output logic       picture_active,
    output logic       output_display,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    import vga_pkg::*;

    localparam int unsigned HT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam coord_t HA    = coord_t'(H_ACT);
    localparam coord_t VA    = coord_t'(V_ACT);
    localparam coord_t HS_LO = coord_t'(H_ACT + H_FP);
    localparam coord_t HS_HI = coord_t'(H_ACT + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO = coord_t'(V_ACT + V_FP);
    localparam coord_t VS_HI = coord_t'(V_ACT + V_FP + V_SYNC - 1);
    localparam coord_t PX_LO = coord_t'(PIC_X);
    localparam coord_t PX_HI = coord_t'(PIC_X + PIC_W - 1);
    localparam coord_t PY_LO = coord_t'(PIC_Y);
    localparam coord_t PY_HI = coord_t'(PIC_Y + PIC_H - 1);

    coord_t     h_cnt;
    coord_t     v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       act;
    logic       origin_q;
    logic       seen_q;
    logic [7:0] frame_cnt_q;
    logic [7:0] frame_cnt_d;
    raster_t    raster_q;
    raster_t    raster_d;

    vga_axis_counter #(
        .TOT (HT)
    ) u_h_cnt (
        .clk    (vga_clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    vga_axis_counter #(
        .TOT (VT)
    ) u_v_cnt (
        .clk    (vga_clk),
        .rst_n  (rst_n),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap)
    );

    // Decode the counter state into the next output sample.
    always_comb begin
        act           = (h_cnt < HA) && (v_cnt < VA);
        raster_d      = RASTER_IDLE;
        raster_d.hs_n = !in_rng(h_cnt, HS_LO, HS_HI);
        raster_d.vs_n = !in_rng(v_cnt, VS_LO, VS_HI);
        raster_d.act  = act;
        raster_d.pic  = act && in_rng(h_cnt, PX_LO, PX_HI)
                            && in_rng(v_cnt, PY_LO, PY_HI);
        raster_d.disp = act && display_en;
        raster_d.fs   = origin_q;
        raster_d.h    = act ? h_cnt : '0;
        raster_d.v    = act ? v_cnt : '0;
    end

    // The (0,0) after reset opens the first frame; later ones close a frame.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (origin_q && seen_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Output register stage; origin_q marks counter (0,0) without a wide compare.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            raster_q    <= RASTER_IDLE;
            frame_cnt_q <= '0;
            seen_q      <= 1'b0;
            origin_q    <= 1'b1;
        end else begin
            raster_q    <= raster_d;
            frame_cnt_q <= frame_cnt_d;
            origin_q    <= v_wrap;
            if (origin_q) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign hsync            = raster_q.hs_n;
    assign vsync            = raster_q.vs_n;
    assign data_read_active = raster_q.act;
    assign picture_active   = raster_q.pic;
    assign output_display   = raster_q.disp;
    assign frame_start      = raster_q.fs;
    assign h_addr           = raster_q.h;
    assign v_addr           = raster_q.v;
    assign frame_cnt        = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream neighbour of the pixel colour stage. Generates 640x480@60 VGA raster timing from the 25.175 MHz pixel clock.
- Produces hsync/vsync, the active-video strobe, pixel coordinates, a sprite/picture window flag, a display gate, a frame-start pulse and a free-running frame counter.
- The colour stage consumes h_addr, v_addr, data_read_active, picture_active and output_display directly; sprite ROM/animation logic uses frame_cnt.

Parameters:
- H_ACT, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACT, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIC_X, 256, picture window left column (inclusive)
- PIC_Y, 176, picture window top row (inclusive)
- PIC_W, 128, picture window width
- PIC_H, 128, picture window height

Ports:
- vga_clk  input  1  pixel clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- display_en  input  1  global display enable (e.g. game-running switch)
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- data_read_active  output  1  high while the pixel is inside the 640x480 visible area
- h_addr  output  10  visible column 0..639; 0 outside the visible area
- v_addr  output  10  visible row 0..479; 0 outside the visible area
- picture_active  output  1  visible and inside the PIC window
- output_display  output  1  data_read_active AND display_en (registered)
- frame_start  output  1  one-clock pulse coinciding with pixel (0,0)
- frame_cnt  output  8  frames completed since reset, wraps 255->0

Behaviour:
- Reset:
  - Asynchronous, active-low, single clock domain (vga_clk). Reset is checked before the clock edge.
  - Internal h_cnt = 0, v_cnt = 0.
  - Outputs: hsync = 1, vsync = 1, data_read_active = 0, h_addr = 0, v_addr = 0, picture_active = 0, output_display = 0, frame_start = 0, frame_cnt = 0.
- Counters:
  - H_TOT = H_ACT+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACT+V_FP+V_SYNC+V_BP (525).
  - h_cnt increments every clock and wraps H_TOT-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and wraps V_TOT-1 -> 0 on the same clock as that h_cnt wrap.
  - Count 0 is the first visible pixel/line. Both counters are 10 bits; no other value is reachable.
- Decode (combinational from the counters):
  - act = (h_cnt < H_ACT) && (v_cnt < V_ACT).
  - hs_n low for h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_n low for v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1], i.e. 490..491, for whole lines.
  - pic = act && PIC_X <= h_cnt < PIC_X+PIC_W && PIC_Y <= v_cnt < PIC_Y+PIC_H.
- Output register stage:
  - Every output is registered. Latency is exactly 1 clock from counter state to outputs, and all outputs are mutually aligned.
  - h_addr/v_addr take h_cnt/v_cnt when act, else 0.
  - output_display takes act && display_en as sampled on the same edge.
- frame_start and frame_cnt:
  - frame_start = 1 on the output cycle for counter (0,0), otherwise 0.
  - frame_cnt increments on the same edge that registers frame_start = 1, so it is already updated when frame_start is seen high.
  - The first (0,0) after reset is not a completed frame: frame_cnt increments only from the second frame_start onward.
- display_en does not affect the counters, the sync outputs or data_read_active; the raster free-runs.
- Reset asserted mid-frame: all outputs are forced to their reset values immediately (asynchronous). After release, timing restarts at (0,0) with no partial-frame artefacts. The first edge after release presents pixel (0,0) with frame_start = 1 and frame_cnt = 0.
- Parameter rule: sync and window ranges must lie within the totals; the design is not required to check this.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_ACT..V_BP, H_TOT, V_TOT);
  - the derived sync start/end values;
  - a 10-bit coordinate typedef (coord_t).
- The colour stage and sprite ROM address logic import the same package.
- One natural sub-module: vga_axis_counter. It is a parameterised counter with wrap and carry-out, instantiated once for h (carry from every clock) and once for v (enabled by the h carry).
- Decode and the output registers stay in the top module.

Test Plan:
- Reset release: hold rst_n = 0 for 5 clocks, then release. The first edge gives h_addr = 0, v_addr = 0, data_read_active = 1, frame_start = 1, hsync = vsync = 1, frame_cnt = 0.
- Line timing: over one line, data_read_active is high for exactly 640 clocks. hsync goes low on output cycle 657 after the line start and stays low for 96 clocks. Line period is 800 clocks.
- Frame timing: vsync is low for exactly 2×800 clocks, starting 490 lines after frame_start. frame_start recurs every 420000 clocks, and frame_cnt goes 0→1→2 across the second and third pulses.
- Picture window: picture_active is high exactly at (256,176) and (383,303), low at (255,176) and (384,303), and 16384 cycles high per frame. With display_en = 0, output_display = 0 throughout while data_read_active still toggles.
- Blanking/wrap: at counter (639,479)→(640,479), h_addr/v_addr go 0 and data_read_active goes 0. frame_cnt wraps 255→0 after 256 completed frames.
- Mid-frame reset: assert rst_n = 0 asynchronously mid-cycle at pixel (300,200). All outputs take their reset values before the next edge, and after release the sequence restarts at (0,0).
